regfile_dump: RTL and testbench

Sequential reader for the 32-entry integer register file. On a start command it takes over the register file read ports and walks x0..x31 two registers at a time via the rs1/rs2 select ports. Each captured value is streamed out as an (index, data) beat over a valid/ready interface. It sits between the register file and the debug/trace path; `busy` tells the core-side mux to hand the read ports to this block.

---
 rtl/regfile_dump.sv | 128 ++++++++++++
 tb/tb_regfile_dump.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks the 32-entry register file two registers per READ cycle
// and streams every value out as an (index, data) beat on a valid/ready port.
// While busy is high this block owns the register file read ports.
module regfile_dump #(
    parameter int width  = 32,
    parameter int regsel = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [regsel-1:0] rs1,
    output logic [regsel-1:0] rs2,
    output logic              rs1v,
    output logic              rs2v,
    input  logic [width-1:0]  dataA,
    input  logic [width-1:0]  dataB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [regsel-1:0] out_idx,
    output logic [width-1:0]  out_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND_A,
        SEND_B,
        DONE
    } state_t;

    localparam logic [regsel-2:0] k_last = '1;

    state_t            state;
    logic [regsel-2:0] k;      // pair counter, pair k covers x(2k) and x(2k+1)
    logic [width-1:0]  buf_b;  // odd-register snapshot; the even one lives in out_data

    // Single FSM: every output is a register loaded on the transition into
    // the state that presents it, so outputs are glitch-free and match the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from the same pre-edge values regardless of statement order.
            state     <= IDLE;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rs1v      <= 1'b0;
            rs2v      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            buf_b     <= '0;
        end else if (abort) begin
            // Cancel wins over every transition, including start in IDLE.
            state     <= IDLE;
            k         <= '0;
            rs1       <= '0;
            rs2       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rs1v      <= 1'b0;
            rs2v      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        k     <= '0;
                        rs1   <= '0;
                        rs2   <= regsel'(1);
                        rs1v  <= 1'b1;
                        rs2v  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    // Read data is combinational from rs1/rs2, valid this cycle.
                    buf_b     <= dataB;
                    out_data  <= dataA;
                    out_idx   <= rs1;
                    out_valid <= 1'b1;
                    rs1v      <= 1'b0;
                    rs2v      <= 1'b0;
                    state     <= SEND_A;
                end
                SEND_A: begin
                    // Hold idx/data stable until the consumer takes the beat.
                    if (out_ready) begin
                        out_idx  <= rs2;
                        out_data <= buf_b;
                        state    <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (k == k_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k     <= k + 1'b1;
                            rs1   <= {k + 1'b1, 1'b0};
                            rs2   <= {k + 1'b1, 1'b1};
                            rs1v  <= 1'b1;
                            rs2v  <= 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file plus an expected beat
// stream (index i carries regs[i]) checked cycle by cycle from the consumer side.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1v;
    logic        rs2v;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    logic [31:0] regs [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, x0 reads zero.
    assign dataA = regs[rs1];
    assign dataB = regs[rs2];

    regfile_dump #(.width(32), .regsel(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1v      (rs1v),
        .rs2v      (rs2v),
        .dataA     (dataA),
        .dataB     (dataB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // One full dump. Start is sampled at edge 0; cycle c is observed at its
    // negedge. random_ready stalls the consumer pseudo-randomly; extra_starts
    // pulses start during cycles 5 and 20 of the running dump.
    task automatic run_dump(input bit random_ready, input bit extra_starts);
        int          exp_idx    = 0;
        int          stalls     = 0;
        int          dones      = 0;
        int          done_cycle = -1;
        int          reads      = 0;
        bit          stalled    = 1'b0;
        bit          rdy;
        logic [4:0]  held_idx   = '0;
        logic [31:0] held_data  = '0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            start = extra_starts && (c == 5 || c == 20);
            if (done_cycle >= 0) begin
                check("busy_after_done", {31'b0, busy}, 32'd0);
                check("done_one_cycle", {31'b0, done}, 32'd0);
                break;
            end
            check("busy_during_dump", {31'b0, busy}, 32'd1);
            check("rs2v_eq_rs1v", {31'b0, rs2v}, {31'b0, rs1v});
            if (rs1v) begin
                reads++;
                check("rs1_even", {27'b0, rs1}, 32'(exp_idx));
                check("rs2_odd", {27'b0, rs2}, 32'(exp_idx + 1));
                check("no_valid_in_read", {31'b0, out_valid}, 32'd0);
            end
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (stalled) begin
                    check("idx_stable", {27'b0, out_idx}, {27'b0, held_idx});
                    check("data_stable", out_data, held_data);
                end
                check("beat_idx", {27'b0, out_idx}, 32'(exp_idx));
                check("beat_data", out_data, regs[exp_idx[4:0]]);
                held_idx  = out_idx;
                held_data = out_data;
                stalled   = !rdy;
                if (rdy) exp_idx++;
                else     stalls++;
            end else begin
                stalled = 1'b0;
            end
            out_ready = rdy;
            if (done) begin
                dones++;
                done_cycle = c;
                check("beats_before_done", 32'(exp_idx), 32'd32);
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check("done_count", 32'(dones), 32'd1);
        check("read_cycles", 32'(reads), 32'd16);
        check("done_cycle", 32'(done_cycle), 32'(49 + stalls));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_rsv"}, {30'b0, rs1v, rs2v}, 32'd0);
        check({tag, "_rs"}, {22'b0, rs1, rs2}, 32'd0);
        check({tag, "_idx"}, {27'b0, out_idx}, 32'd0);
        check({tag, "_data"}, out_data, 32'd0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'hA500_0000 + 32'(i);
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Plain dump, then consumer backpressure, then ignored starts.
        run_dump(1'b0, 1'b0);
        run_dump(1'b1, 1'b0);
        run_dump(1'b1, 1'b0);
        run_dump(1'b0, 1'b1);

        // Abort while idx 15 (SEND_B of pair 7) is pending.
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_idx == 5'd15) begin
                found     = 1'b1;
                out_ready = 1'b0;
                abort     = 1'b1;
            end
        end
        check("abort_target_reached", {31'b0, found}, 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_rs", {22'b0, rs1, rs2}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("abort_no_done", {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        run_dump(1'b0, 1'b0);

        // Asynchronous reset in the middle of SEND_A of pair 2.
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_idx == 5'd4) begin
                found     = 1'b1;
                out_ready = 1'b0;
            end
        end
        check("rst_target_reached", {31'b0, found}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_done", {31'b0, done}, 32'd0);
        run_dump(1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
